fb_write_sched: RTL and testbench

FB_WRITE_SCHED -- requirements
Module: fb_write_sched

---
 rtl/fb_write_sched.sv | 154 +++++++++++++++
 tb/tb_fb_write_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_sched.sv
// Pixel write scheduler: queues input pixels in a small FIFO and issues them as
// single-beat DDRAM writes, while tracking the input/output buffer indices.
module fb_write_sched #(
    parameter logic [6:0] MEM_BASE = 7'b0010010,
    parameter int         DEPTH    = 16
) (
    input  logic        clk_video,
    input  logic        reset,
    input  logic        pix_we,
    input  logic [22:0] pix_addr,
    input  logic [31:0] pix_data,
    input  logic        frame_start,
    input  logic        fb_vbl,
    input  logic        fb_ll,
    input  logic        ddram_busy,
    output logic        ddram_we,
    output logic [28:0] ddram_addr,
    output logic [63:0] ddram_din,
    output logic [7:0]  ddram_be,
    output logic [7:0]  ddram_burstcnt,
    output logic [1:0]  i_fb,
    output logic [1:0]  o_fb,
    output logic [6:0]  fifo_level,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);

    // Entry layout: {word address [22:2], pixel data, buffer tag}
    localparam int EW = 21 + 32 + 2;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [6:0]    count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          we_q, we_d;
    logic [28:0]   addr_q, addr_d;
    logic [63:0]   din_q, din_d;
    logic [7:0]    be_q, be_d;
    logic [1:0]    i_fb_q, i_fb_d;
    logic [1:0]    o_fb_q, o_fb_d;
    logic          vbl_q, vbl_d;

    logic          push;
    logic          pop;
    logic          full;
    logic [EW-1:0] new_entry;
    logic [EW-1:0] head;
    logic          vbl_rise;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, pix_addr[1:0]};

    // Index in {0,1,2} that differs from both arguments.
    function automatic logic [1:0] third(input logic [1:0] a, input logic [1:0] b);
        if (a != 2'd0 && b != 2'd0)
            return 2'd0;
        else if (a != 2'd1 && b != 2'd1)
            return 2'd1;
        else
            return 2'd2;
    endfunction

    always_comb begin
        full       = !(count_q < 7'(DEPTH));
        push       = pix_we & ~full;
        pop        = we_q & ~ddram_busy;
        new_entry  = {pix_addr[22:2], pix_data, i_fb_q};
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + 7'(push) - 7'(pop);
        overflow_d = overflow_q | (pix_we & full);

        // When the FIFO drains to nothing this cycle, the incoming pixel becomes the head directly.
        if ((count_q - 7'(pop)) == 7'd0)
            head = new_entry;
        else
            head = mem_q[rd_ptr_d];

        we_d   = (count_d != 7'd0);
        addr_d = addr_q;
        din_d  = din_q;
        be_d   = be_q;
        if (count_d != 7'd0) begin
            addr_d = {MEM_BASE, head[1:0], head[EW-1:EW-20]};
            din_d  = {head[33:2], head[33:2]};
            be_d   = head[34] ? 8'hF0 : 8'h0F;
        end
    end

    always_comb begin
        vbl_rise = fb_vbl & ~vbl_q;
        vbl_d    = fb_vbl;
        i_fb_d   = i_fb_q;
        o_fb_d   = o_fb_q;
        if (fb_ll) begin
            if (frame_start)
                i_fb_d = {1'b0, ~i_fb_q[0]};
            if (vbl_rise)
                o_fb_d = {1'b0, ~i_fb_q[0]};
        end else begin
            if (frame_start)
                i_fb_d = third(i_fb_q, o_fb_q);
            // Output picks against the input index being loaded now, so they never collide.
            if (vbl_rise)
                o_fb_d = third(o_fb_q, i_fb_d);
        end
    end

    always_ff @(posedge clk_video) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            be_q       <= '0;
            i_fb_q     <= 2'd0;
            o_fb_q     <= 2'd1;
            vbl_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            be_q       <= be_d;
            i_fb_q     <= i_fb_d;
            o_fb_q     <= o_fb_d;
            vbl_q      <= vbl_d;
        end
    end

    always_ff @(posedge clk_video) begin
        if (!reset && push)
            mem_q[wr_ptr_q] <= new_entry;
    end

    assign ddram_we       = we_q;
    assign ddram_addr     = addr_q;
    assign ddram_din      = din_q;
    assign ddram_be       = be_q;
    assign ddram_burstcnt = 8'd1;
    assign i_fb           = i_fb_q;
    assign o_fb           = o_fb_q;
    assign fifo_level     = count_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_fb_write_sched.sv
// Directed bench for fb_write_sched: FIFO issue path, overflow, buffer rotation, reset.
module tb_fb_write_sched;
  localparam logic [6:0] MB = 7'b0010010;

  logic        clk_video = 1'b0;
  logic        reset;
  logic        pix_we;
  logic [22:0] pix_addr;
  logic [31:0] pix_data;
  logic        frame_start;
  logic        fb_vbl;
  logic        fb_ll;
  logic        ddram_busy;
  logic        ddram_we;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic [7:0]  ddram_burstcnt;
  logic [1:0]  i_fb;
  logic [1:0]  o_fb;
  logic [6:0]  fifo_level;
  logic        overflow;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [28:0] exp_a_q[$];
  logic [7:0]  exp_be_q[$];

  always #5 clk_video = ~clk_video;

  fb_write_sched dut (
    .clk_video      (clk_video),
    .reset          (reset),
    .pix_we         (pix_we),
    .pix_addr       (pix_addr),
    .pix_data       (pix_data),
    .frame_start    (frame_start),
    .fb_vbl         (fb_vbl),
    .fb_ll          (fb_ll),
    .ddram_busy     (ddram_busy),
    .ddram_we       (ddram_we),
    .ddram_addr     (ddram_addr),
    .ddram_din      (ddram_din),
    .ddram_be       (ddram_be),
    .ddram_burstcnt (ddram_burstcnt),
    .i_fb           (i_fb),
    .o_fb           (o_fb),
    .fifo_level     (fifo_level),
    .overflow       (overflow)
  );

  function automatic logic [28:0] fx_addr(input logic [1:0] tag, input logic [22:0] a);
    return {MB, tag, a[22:3]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_video);
    #1;
  endtask

  task automatic push(input logic [22:0] a, input logic [31:0] d);
    pix_we   = 1'b1;
    pix_addr = a;
    pix_data = d;
    step();
    pix_we   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [22:0] a;
    logic [31:0] d;
    logic [1:0]  exp_i[6];
    logic [1:0]  exp_o[6];
    logic [1:0]  ll_i[3];
    logic [1:0]  ll_o[3];
    int          writes;

    // Reset with every input active: all of it must be ignored.
    reset = 1'b1; pix_we = 1'b1; pix_addr = 23'h10; pix_data = 32'h1111_1111;
    frame_start = 1'b1; fb_vbl = 1'b1; fb_ll = 1'b0; ddram_busy = 1'b0;
    step(); step(); step();
    chk("rst_level", fifo_level, 0);
    chk("rst_we", ddram_we, 0);
    chk("rst_addr", ddram_addr, 0);
    chk("rst_din", ddram_din, 0);
    chk("rst_be", ddram_be, 0);
    chk("rst_i_fb", i_fb, 0);
    chk("rst_o_fb", o_fb, 1);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0; pix_we = 1'b0; frame_start = 1'b0; fb_vbl = 1'b0;
    step();
    chk("idle_we", ddram_we, 0);
    chk("burstcnt", ddram_burstcnt, 1);

    // Single push, one-cycle latency.
    push(23'h000010, 32'h00AB_CDEF);
    chk("single_we", ddram_we, 1);
    chk("single_addr", ddram_addr, {MB, 2'd0, 20'h00002});
    chk("single_be", ddram_be, 8'h0F);
    chk("single_din", ddram_din, 64'h00ABCDEF00ABCDEF);
    chk("single_level", fifo_level, 1);
    step();
    chk("single_drain_we", ddram_we, 0);
    chk("single_drain_level", fifo_level, 0);

    // Busy for 20 cycles with 18 pushes: 16 stored, 2 dropped.
    ddram_busy = 1'b1;
    for (int i = 0; i < 18; i++) begin
      a = 23'(i * 4);
      d = 32'hA000_0000 | 32'(i);
      if (i < 16) begin
        exp_q.push_back({d, d});
        exp_a_q.push_back(fx_addr(2'd0, a));
        exp_be_q.push_back(a[2] ? 8'hF0 : 8'h0F);
      end
      push(a, d);
    end
    chk("ovf_level", fifo_level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_hold_we", ddram_we, 1);
    chk("ovf_hold_din", ddram_din, 64'hA0000000A0000000);
    step(); step();
    chk("ovf_hold_addr", ddram_addr, {MB, 2'd0, 20'h0});
    chk("ovf_hold_din2", ddram_din, 64'hA0000000A0000000);
    chk("ovf_hold_be", ddram_be, 8'h0F);

    // Release busy while also pushing into the full FIFO: that push is dropped.
    ddram_busy = 1'b0;
    pix_we = 1'b1; pix_addr = 23'h7FFFFC; pix_data = 32'hDEAD_BEEF;
    writes = 0;
    for (int k = 0; k < 20; k++) begin
      if (ddram_we === 1'b1) begin
        writes++;
        if (exp_q.size() > 0) begin
          chk("drain_din", ddram_din, exp_q.pop_front());
          chk("drain_addr", ddram_addr, exp_a_q.pop_front());
          chk("drain_be", ddram_be, exp_be_q.pop_front());
        end
      end
      step();
      if (k == 0) begin
        pix_we = 1'b0;
        chk("full_pop_no_push_level", fifo_level, 15);
      end
    end
    chk("drain_writes", writes, 16);
    chk("drain_level", fifo_level, 0);
    chk("overflow_sticky", overflow, 1);

    // Tag captured at push time survives an i_fb change.
    ddram_busy = 1'b1;
    push(23'h000004, 32'h0000_00C1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("tag_i_fb", i_fb, 2);
    chk("tag_o_fb", o_fb, 1);
    push(23'h000008, 32'h0000_00C2);
    chk("tag_first_addr", ddram_addr, {MB, 2'd0, 20'h0});
    chk("tag_first_be", ddram_be, 8'hF0);
    chk("tag_level", fifo_level, 2);
    ddram_busy = 1'b0;
    step();
    chk("tag_second_addr", ddram_addr, {MB, 2'd2, 20'h1});
    chk("tag_second_be", ddram_be, 8'h0F);
    chk("tag_second_din", ddram_din, 64'h000000C2000000C2);
    step();
    chk("tag_drain_we", ddram_we, 0);

    // Triple buffering: simultaneous events from reset state, then 6 frames.
    do_reset();
    fb_ll = 1'b0;
    frame_start = 1'b1; fb_vbl = 1'b1;
    step();
    frame_start = 1'b0;
    chk("tri_sim_i", i_fb, 2);
    chk("tri_sim_o", o_fb, 0);
    exp_i = '{2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2};
    exp_o = '{2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};
    for (int f = 0; f < 6; f++) begin
      fb_vbl = 1'b0;
      step();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("tri_i", i_fb, exp_i[f]);
      chk("tri_distinct_fs", i_fb != o_fb, 1);
      fb_vbl = 1'b1;
      step();
      chk("tri_o", o_fb, exp_o[f]);
      chk("tri_distinct_vbl", i_fb != o_fb, 1);
    end
    fb_vbl = 1'b0;

    // Double buffering.
    do_reset();
    fb_ll = 1'b1;
    step();
    ll_i = '{2'd1, 2'd0, 2'd1};
    ll_o = '{2'd0, 2'd1, 2'd0};
    for (int f = 0; f < 3; f++) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("ll_i", i_fb, ll_i[f]);
      fb_vbl = 1'b1;
      step();
      fb_vbl = 1'b0;
      chk("ll_o", o_fb, ll_o[f]);
      step();
    end

    // Reset with queued writes held by busy.
    do_reset();
    fb_ll = 1'b0;
    ddram_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(23'(i * 8), 32'h5000_0000 | 32'(i));
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("mid_level", fifo_level, 5);
    chk("mid_i_fb", i_fb, 2);
    reset = 1'b1;
    step();
    chk("mid_rst_we", ddram_we, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_i_fb", i_fb, 0);
    chk("mid_rst_o_fb", o_fb, 1);
    chk("mid_rst_addr", ddram_addr, 0);
    reset = 1'b0; ddram_busy = 1'b0;
    push(23'h000020, 32'h1234_5678);
    chk("post_rst_we", ddram_we, 1);
    chk("post_rst_level", fifo_level, 1);
    chk("post_rst_din", ddram_din, 64'h1234567812345678);
    chk("post_rst_addr", ddram_addr, fx_addr(2'd0, 23'h000020));
    step();
    chk("post_rst_drain_we", ddram_we, 0);
    chk("post_rst_drain_level", fifo_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
